// File: rtl/edge_detect_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg
// Description : Shared definitions for the multi-channel edge detector:
//               per-channel mode encoding, default parameter values and a
//               width helper for the optional debounce counter.
// Macros      : EDGE_DEBOUNCE_EN (consumed by edge_chan, not here)
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg;

  // Per-channel mode field. Bit 0 enables rising edges, bit 1 enables
  // falling edges, so MODE_BOTH is simply the OR of the other two.
  typedef logic [1:0] edge_mode_t;

  localparam edge_mode_t MODE_OFF  = 2'b00;
  localparam edge_mode_t MODE_RISE = 2'b01;
  localparam edge_mode_t MODE_FALL = 2'b10;
  localparam edge_mode_t MODE_BOTH = 2'b11;

  // Default parameter values shared by the interface, channel and top.
  localparam int   DEF_CH          = 8;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam int   DEF_CNT_W       = 8;
  localparam logic DEF_INIT_LEVEL  = 1'b0;
  localparam int   DEF_FILT_LEN    = 4;

  // Width of the debounce run-length counter. It must hold 0..FILT_LEN.
  function automatic int filt_cnt_w(input int filt_len);
    return (filt_len < 1) ? 1 : $clog2(filt_len + 1);
  endfunction

endpackage : edge_pkg
`default_nettype wire

// File: rtl/edge_detect_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_multi_if
// Description : Bundles the per-channel inputs and status outputs of the
//               multi-channel edge detector.
// Signals     : i_din    [CH]        asynchronous input levels
//               i_mode   [2*CH]      per-channel mode, channel k at [2k+1:2k]
//               i_clr    [CH]        per-channel sticky/counter clear strobe
//               o_pulse  [CH]        one-cycle edge pulse
//               o_sticky [CH]        latched edge-seen flag
//               o_cnt    [CH*CNT_W]  saturating counts, channel k at
//                                    [k*CNT_W +: CNT_W]
//               o_irq                OR of all sticky flags
// Modports    : master - drives inputs, observes status (stimulus side)
//               slave  - the detector itself
// Revision    : 1.0 - initial release
// ============================================================================
interface edge_detect_multi_if
  import edge_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [CH-1:0]       i_din;
  logic [2*CH-1:0]     i_mode;
  logic [CH-1:0]       i_clr;
  logic [CH-1:0]       o_pulse;
  logic [CH-1:0]       o_sticky;
  logic [CH*CNT_W-1:0] o_cnt;
  logic                o_irq;

  modport master (
    output i_din,
    output i_mode,
    output i_clr,
    input  o_pulse,
    input  o_sticky,
    input  o_cnt,
    input  o_irq
  );

  modport slave (
    input  i_din,
    input  i_mode,
    input  i_clr,
    output o_pulse,
    output o_sticky,
    output o_cnt,
    output o_irq
  );

endinterface : edge_detect_multi_if
`default_nettype wire

// File: rtl/edge_detect_multi_chan.sv
`default_nettype none
// ============================================================================
// Module      : edge_chan
// Description : One channel of the edge detector: synchroniser chain,
//               optional debounce filter, rise/fall detector, registered
//               pulse, write-1-to-clear sticky flag and saturating counter.
// Ports       : i_clk    clock, all flops on the rising edge
//               i_rstn   asynchronous active-low reset
//               i_din    asynchronous input level
//               i_mode   edge_mode_t, bit0 = rise enable, bit1 = fall enable
//               i_clr    clear strobe for sticky flag and counter
//               o_pulse  one-cycle registered edge pulse
//               o_sticky latched edge-seen flag
//               o_cnt    saturating event count
// Macros      : EDGE_DEBOUNCE_EN - when defined, edges are detected on a
//               filtered level that only follows the synchronised input
//               after FILT_LEN consecutive differing cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_chan
  import edge_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic INIT_LEVEL  = DEF_INIT_LEVEL,
  parameter int   FILT_LEN    = DEF_FILT_LEN
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_din,
  input  edge_mode_t       i_mode,
  input  logic             i_clr,
  output logic             o_pulse,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   sync_out_w;  // last synchroniser stage
  logic                   level_w;     // level the detector compares
  logic                   rise_w;
  logic                   fall_w;
  logic                   det_w;

  // --------------------------------------------------------------------------
  // Synchroniser: stage 0 samples the asynchronous input, the level then
  // shifts towards stage SYNC_STAGES-1 one flop per cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_din};
  end

  assign sync_out_w = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef EDGE_DEBOUNCE_EN
  // --------------------------------------------------------------------------
  // Debounce filter: filt_q only adopts the synchronised level once it has
  // disagreed for FILT_LEN consecutive cycles. Any cycle of agreement
  // restarts the run, so shorter glitches never reach the detector.
  // --------------------------------------------------------------------------
  localparam int                FCNT_W    = filt_cnt_w(FILT_LEN);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILT_LEN - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1);

  logic              filt_q, filt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (sync_out_w == filt_q) begin
      fcnt_d = '0;
    end else if (fcnt_q == FCNT_LAST) begin
      // This is the FILT_LEN-th consecutive differing cycle.
      filt_d = sync_out_w;
      fcnt_d = '0;
    end else begin
      fcnt_d = fcnt_q + FCNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      filt_q <= INIT_LEVEL;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign level_w = filt_q;
`else
  // FILT_LEN only shapes the filter; without it the parameter is folded
  // into a sink so the unfiltered build carries no dangling parameter.
  logic unused_filt_len;
  assign unused_filt_len = ^FILT_LEN;

  assign level_w = sync_out_w;
`endif

  // --------------------------------------------------------------------------
  // Edge detector. prev_q holds the level one cycle older than level_w, so
  // a mode change only affects comparisons made from the next edge on.
  // --------------------------------------------------------------------------
  always_comb begin
    rise_w = level_w & ~prev_q;
    fall_w = ~level_w & prev_q;
    det_w  = (i_mode[0] & rise_w) | (i_mode[1] & fall_w);
  end

  // --------------------------------------------------------------------------
  // Status next-state. A detection in the same cycle as a clear wins: the
  // flag stays set and the counter restarts at one instead of zero.
  // --------------------------------------------------------------------------
  always_comb begin
    prev_d   = level_w;
    pulse_d  = det_w;
    sticky_d = det_w | (sticky_q & ~i_clr);
    cnt_d    = cnt_q;
    if (i_clr) begin
      cnt_d = det_w ? CNT_ONE : '0;
    end else if (det_w && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      prev_q   <= INIT_LEVEL;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_pulse  = pulse_q;
  assign o_sticky = sticky_q;
  assign o_cnt    = cnt_q;

endmodule : edge_chan
`default_nettype wire

// File: rtl/edge_detect_multi.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_multi
// Description : Parametrised multi-channel synchronising edge detector.
//               Replicates edge_chan CH times and ORs the sticky flags into
//               a single interrupt line (combinational, no added latency).
// Ports       : i_clk  clock, all flops on the rising edge
//               i_rstn asynchronous active-low reset
//               bus    edge_detect_multi_if.slave carrying i_din, i_mode,
//                      i_clr, o_pulse, o_sticky, o_cnt and o_irq
// Parameters  : CH, SYNC_STAGES, CNT_W, INIT_LEVEL, FILT_LEN. The interface
//               instance must be built with the same CH and CNT_W.
// Macros      : EDGE_DEBOUNCE_EN - enables the per-channel debounce filter.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int   CH          = DEF_CH,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic INIT_LEVEL  = DEF_INIT_LEVEL,
  parameter int   FILT_LEN    = DEF_FILT_LEN
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  edge_detect_multi_if.slave bus
);

  logic [CH-1:0]       w_pulse;
  logic [CH-1:0]       w_sticky;
  logic [CH*CNT_W-1:0] w_cnt;

  for (genvar k = 0; k < CH; k++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .INIT_LEVEL  (INIT_LEVEL),
      .FILT_LEN    (FILT_LEN)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .i_din    (bus.i_din[k]),
      .i_mode   (bus.i_mode[2*k +: 2]),
      .i_clr    (bus.i_clr[k]),
      .o_pulse  (w_pulse[k]),
      .o_sticky (w_sticky[k]),
      .o_cnt    (w_cnt[k*CNT_W +: CNT_W])
    );
  end : g_chan

  assign bus.o_pulse  = w_pulse;
  assign bus.o_sticky = w_sticky;
  assign bus.o_cnt    = w_cnt;
  assign bus.o_irq    = |w_sticky;

endmodule : edge_detect_multi
`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_detect_multi
// Description : Self-checking bench for edge_detect_multi. Two instances
//               share one stimulus: a wide-counter one (CNT_W=8) and a
//               narrow one (CNT_W=2) that exposes saturation. Expected
//               values come from a history-based model of the input levels.
// Macros      : EDGE_DEBOUNCE_EN - model and directed expectations follow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_detect_multi;
  import edge_pkg::*;

  localparam int   CH          = 8;
  localparam int   SYNC_STAGES = 2;
  localparam int   CNT_W       = 8;
  localparam int   CNT_W_SAT   = 2;
  localparam logic INIT_LEVEL  = 1'b0;
  localparam int   FILT_LEN    = 4;
  localparam int   HIST_MAX    = 16;
`ifdef EDGE_DEBOUNCE_EN
  localparam bit   DEB         = 1'b1;
  localparam int   LAT_EXTRA   = FILT_LEN;
`else
  localparam bit   DEB         = 1'b0;
  localparam int   LAT_EXTRA   = 0;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [CH-1:0]   din;
  logic [CH-1:0]   clr;
  logic [2*CH-1:0] mode;

  edge_detect_multi_if #(.CH(CH), .CNT_W(CNT_W))     bus ();
  edge_detect_multi_if #(.CH(CH), .CNT_W(CNT_W_SAT)) bus_sat ();

  assign bus.i_din      = din;
  assign bus.i_mode     = mode;
  assign bus.i_clr      = clr;
  assign bus_sat.i_din  = din;
  assign bus_sat.i_mode = mode;
  assign bus_sat.i_clr  = clr;

  edge_detect_multi #(
    .CH(CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W),
    .INIT_LEVEL(INIT_LEVEL), .FILT_LEN(FILT_LEN)
  ) u_dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave)
  );

  edge_detect_multi #(
    .CH(CH), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W_SAT),
    .INIT_LEVEL(INIT_LEVEL), .FILT_LEN(FILT_LEN)
  ) u_dut_sat (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus_sat.slave)
  );

  // --------------------------------------------------------------------------
  // Reference model: histories of sampled input, synchronised level and the
  // level seen by the detector (filtered when debounce is built in).
  // --------------------------------------------------------------------------
  logic [CH-1:0] din_h[$];
  logic [CH-1:0] s_h[$];
  logic [CH-1:0] d_h[$];
  logic [CH-1:0] exp_pulse;
  logic [CH-1:0] exp_sticky;
  int            exp_cnt[CH];
  int            exp_cnt_sat[CH];

  int n_cmp   = 0;
  int n_bad   = 0;
  int edge_no = 0;

  task automatic model_reset();
    din_h.delete();
    s_h.delete();
    d_h.delete();
    for (int i = 0; i < HIST_MAX; i++) begin
      din_h.push_back({CH{INIT_LEVEL}});
      s_h.push_back({CH{INIT_LEVEL}});
      d_h.push_back({CH{INIT_LEVEL}});
    end
    exp_pulse  = '0;
    exp_sticky = '0;
    for (int k = 0; k < CH; k++) begin
      exp_cnt[k]     = 0;
      exp_cnt_sat[k] = 0;
    end
  endtask

  // Called right after a rising edge, with din/mode/clr still at the values
  // that edge sampled.
  task automatic model_edge();
    logic [CH-1:0] s_new, f_prev, f_new, d1, d2, det;
    bit            all_diff;
    int            max_main, max_sat;
    max_main = (1 << CNT_W) - 1;
    max_sat  = (1 << CNT_W_SAT) - 1;

    din_h.push_back(din);
    // The last synchroniser stage shows the input sampled SYNC_STAGES-1
    // edges ago.
    s_new = din_h[din_h.size() - SYNC_STAGES];

    if (DEB) begin
      // Filtered level flips once the last FILT_LEN synchronised samples
      // all disagree with it.
      f_prev = d_h[d_h.size() - 1];
      for (int k = 0; k < CH; k++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= FILT_LEN; j++)
          if (s_h[s_h.size() - j][k] == f_prev[k]) all_diff = 1'b0;
        f_new[k] = all_diff ? ~f_prev[k] : f_prev[k];
      end
    end else begin
      f_new = s_new;
    end
    s_h.push_back(s_new);

    // An edge is reported when the detector level changed between the two
    // most recent cycles and the channel mode admits that direction.
    d1 = d_h[d_h.size() - 1];
    d2 = d_h[d_h.size() - 2];
    for (int k = 0; k < CH; k++) begin
      det[k] = (mode[2*k]   && d1[k] && !d2[k]) ||
               (mode[2*k+1] && !d1[k] && d2[k]);
    end
    d_h.push_back(f_new);

    exp_pulse  = det;
    exp_sticky = det | (exp_sticky & ~clr);
    for (int k = 0; k < CH; k++) begin
      if (clr[k]) begin
        exp_cnt[k]     = det[k] ? 1 : 0;
        exp_cnt_sat[k] = det[k] ? 1 : 0;
      end else if (det[k]) begin
        exp_cnt[k]     = (exp_cnt[k] < max_main) ? exp_cnt[k] + 1 : max_main;
        exp_cnt_sat[k] = (exp_cnt_sat[k] < max_sat) ? exp_cnt_sat[k] + 1 : max_sat;
      end
    end

    while (din_h.size() > HIST_MAX) void'(din_h.pop_front());
    while (s_h.size() > HIST_MAX)   void'(s_h.pop_front());
    while (d_h.size() > HIST_MAX)   void'(d_h.pop_front());
  endtask

  function automatic logic [63:0] pack_main();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < CH; k++) v[k*CNT_W +: CNT_W] = CNT_W'(exp_cnt[k]);
    return v;
  endfunction

  function automatic logic [63:0] pack_sat();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < CH; k++) v[k*CNT_W_SAT +: CNT_W_SAT] = CNT_W_SAT'(exp_cnt_sat[k]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp_v, edge_no);
    end
  endtask

  task automatic check_all();
    chk("pulse",      bus.o_pulse,      exp_pulse);
    chk("sticky",     bus.o_sticky,     exp_sticky);
    chk("irq",        bus.o_irq,        |exp_sticky);
    chk("cnt",        bus.o_cnt,        pack_main());
    chk("sat_pulse",  bus_sat.o_pulse,  exp_pulse);
    chk("sat_sticky", bus_sat.o_sticky, exp_sticky);
    chk("sat_irq",    bus_sat.o_irq,    |exp_sticky);
    chk("sat_cnt",    bus_sat.o_cnt,    pack_sat());
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      edge_no++;
      #1;
      check_all();
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence followed by a randomised soak.
  // --------------------------------------------------------------------------
  initial begin
    din  = '0;
    clr  = '0;
    mode = {CH{MODE_RISE}};
    rstn = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rstn = 1'b1;

    // First rising edge on channel 0, raised before edge 10
    edge_no = 0;
    step(9);
    din[0] = 1'b1;
    step(2 + LAT_EXTRA);
    chk("t1_pulse0_early", bus.o_pulse[0], 1'b0);
    step(1);
    chk("t1_pulse0",  bus.o_pulse[0],       1'b1);
    chk("t1_sticky0", bus.o_sticky[0],      1'b1);
    chk("t1_cnt0",    bus.o_cnt[0 +: CNT_W], 8'd1);
    chk("t1_irq",     bus.o_irq,            1'b1);
    step(1);
    chk("t1_pulse0_late", bus.o_pulse[0], 1'b0);

    // Channel 3 in both-edge mode, toggled every cycle
    mode[2*3 +: 2] = MODE_BOTH;
    for (int i = 0; i < 6; i++) begin
      din[3] = ~din[3];
      step(1);
    end
    step(SYNC_STAGES + 2 + LAT_EXTRA);
    chk("t2_cnt3", bus.o_cnt[3*CNT_W +: CNT_W], DEB ? 8'd0 : 8'd6);

    // Five rising edges on channel 1: narrow counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      din[1] = 1'b1;
      step(6);
      din[1] = 1'b0;
      step(6);
      chk("t3_sat_cnt1", bus_sat.o_cnt[1*CNT_W_SAT +: CNT_W_SAT], (i < 3) ? 2'(i + 1) : 2'd3);
      chk("t3_cnt1",     bus.o_cnt[1*CNT_W +: CNT_W], 8'(i + 1));
    end

    // Clear coinciding with a detection on channel 2, then clear alone
    din[2] = 1'b1;
    step(8);
    din[2] = 1'b0;
    step(8);
    din[2] = 1'b1;
    step(SYNC_STAGES + LAT_EXTRA);
    clr[2] = 1'b1;
    step(1);
    chk("t4_pulse2",  bus.o_pulse[2],              1'b1);
    chk("t4_sticky2", bus.o_sticky[2],             1'b1);
    chk("t4_cnt2",    bus.o_cnt[2*CNT_W +: CNT_W], 8'd1);
    step(1);
    clr[2] = 1'b0;
    chk("t4_sticky2_clr", bus.o_sticky[2],             1'b0);
    chk("t4_cnt2_clr",    bus.o_cnt[2*CNT_W +: CNT_W], 8'd0);

    // Channel 5 falling-only, then switched off
    mode[2*5 +: 2] = MODE_FALL;
    din[5] = 1'b1;
    step(8);
    chk("t5_cnt5_rise", bus.o_cnt[5*CNT_W +: CNT_W], 8'd0);
    din[5] = 1'b0;
    step(8);
    chk("t5_cnt5_fall", bus.o_cnt[5*CNT_W +: CNT_W], 8'd1);
    mode[2*5 +: 2] = MODE_OFF;
    din[5] = 1'b1;
    step(8);
    din[5] = 1'b0;
    step(8);
    chk("t5_cnt5_off", bus.o_cnt[5*CNT_W +: CNT_W], 8'd1);

    // Glitch rejection on channel 7: 3-cycle glitch, then 4-cycle level
    din[7] = 1'b1;
    step(3);
    din[7] = 1'b0;
    step(10);
    chk("t7_cnt7_glitch", bus.o_cnt[7*CNT_W +: CNT_W], DEB ? 8'd0 : 8'd1);
    din[7] = 1'b1;
    step(4);
    din[7] = 1'b0;
    step(10);
    chk("t7_cnt7_level", bus.o_cnt[7*CNT_W +: CNT_W], DEB ? 8'd1 : 8'd2);

    // Asynchronous reset mid-cycle while an edge is in the synchroniser
    mode[2*6 +: 2] = MODE_BOTH;
    din[6] = 1'b1;
    step(1);
    #3;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("t6_pulse_rst",  bus.o_pulse,  '0);
    chk("t6_sticky_rst", bus.o_sticky, '0);
    chk("t6_cnt_rst",    bus.o_cnt,    '0);
    chk("t6_irq_rst",    bus.o_irq,    1'b0);
    din = '0;
    @(negedge clk);
    rstn = 1'b1;
    step(10 + LAT_EXTRA);
    chk("t6_cnt_after", bus.o_cnt, '0);

    // Randomised soak with mode changes, sparse clears and one reset
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < CH; k++) begin
        if (c < 200) begin
          if ($urandom_range(3) == 0) din[k] = ~din[k];
        end else begin
          if ($urandom_range(9) == 0) din[k] = ~din[k];
        end
      end
      if ($urandom_range(15) == 0) mode = 16'($urandom);
      clr = CH'($urandom & $urandom & $urandom);
      if (c == 300) begin
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rstn = 1'b1;
      end
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_edge_detect_multi
`default_nettype wire
